// File: rtl/accel_divider_pkg.sv
// Shared accelerator-port definitions: id width, per-accelerator ids,
// register width and the divider FSM state encoding.
package accel_divider_pkg;

  localparam int ACCEL_ID_WIDTH = 4;
  localparam int REG_WIDTH      = 16;

  localparam logic [ACCEL_ID_WIDTH-1:0] ACCEL_ID_DIVIDER = 4'd1;

  // State encodings are fixed so every accelerator FSM on the bus decodes alike.
  localparam logic [2:0] ACCEL_ST_IDLE     = 3'd0;
  localparam logic [2:0] ACCEL_ST_WAIT_OP2 = 3'd1;
  localparam logic [2:0] ACCEL_ST_BUSY     = 3'd2;
  localparam logic [2:0] ACCEL_ST_RES_A    = 3'd3;
  localparam logic [2:0] ACCEL_ST_RES_B    = 3'd4;

  typedef enum logic [2:0] {
    DIV_IDLE     = ACCEL_ST_IDLE,
    DIV_WAIT_DIV = ACCEL_ST_WAIT_OP2,
    DIV_BUSY     = ACCEL_ST_BUSY,
    DIV_RES_Q    = ACCEL_ST_RES_A,
    DIV_RES_R    = ACCEL_ST_RES_B
  } div_state_t;

endpackage

// File: rtl/accel_divider_if.sv
// CPU accelerator port (WACC/RACC). The CPU is the master and the accelerator
// is the slave.
interface accel_divider_if #(parameter int WIDTH = accel_divider_pkg::REG_WIDTH);

  logic [accel_divider_pkg::ACCEL_ID_WIDTH-1:0] accel_id;
  logic                                         accel_can_read;
  logic                                         accel_can_write;
  logic                                         accel_read_enable;
  logic [WIDTH-1:0]                             accel_read_data;
  logic                                         accel_write_enable;
  logic [WIDTH-1:0]                             accel_write_data;

  modport master (
    output accel_id, accel_read_enable, accel_write_enable, accel_write_data,
    input  accel_can_read, accel_can_write, accel_read_data
  );

  modport slave (
    input  accel_id, accel_read_enable, accel_write_enable, accel_write_data,
    output accel_can_read, accel_can_write, accel_read_data
  );

endinterface

// File: rtl/accel_divider_core.sv
// Restoring shift-subtract unsigned divider.
// It produces one quotient bit per cycle over exactly WIDTH cycles after start.
module accel_divider_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] dvd_shift;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] quot;
  logic [WIDTH:0]   rem;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             fits;

  // Bit WIDTH of the trial difference is the borrow, so a clear bit means the divisor fits.
  always_comb begin
    rem_shift = {rem[WIDTH-1:0], dvd_shift[WIDTH-1]};
    trial     = rem_shift - {1'b0, divisor_reg};
    fits      = ~trial[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_shift   <= '0;
      divisor_reg <= '0;
      quot        <= '0;
      rem         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
    end else if (start) begin
      dvd_shift   <= dividend;
      divisor_reg <= divisor;
      quot        <= '0;
      rem         <= '0;
      cnt         <= '0;
      busy        <= 1'b1;
    end else if (busy) begin
      dvd_shift <= {dvd_shift[WIDTH-2:0], 1'b0};
      quot      <= {quot[WIDTH-2:0], fits};
      rem       <= fits ? trial : rem_shift;
      cnt       <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH - 1)) begin
        busy <= 1'b0;
      end
    end
  end

  assign done      = busy && (cnt == CNT_W'(WIDTH - 1));
  assign quotient  = quot;
  assign remainder = rem[WIDTH-1:0];

endmodule

// File: rtl/accel_divider.sv
// Divider accelerator that responds on the shared accel bus.
// Define ACCEL_DIVIDER_SIGNED_EN to select two's-complement operands.
module accel_divider
  import accel_divider_pkg::*;
#(
  parameter logic [ACCEL_ID_WIDTH-1:0] ACCEL_ID = ACCEL_ID_DIVIDER,
  parameter int                        WIDTH    = REG_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  accel_divider_if.slave bus
);

  div_state_t       state;
  div_state_t       state_next;
  logic             sel;
  logic             can_write_int;
  logic             can_read_int;
  logic             core_start;
  logic             core_done;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] core_dividend;
  logic [WIDTH-1:0] core_divisor;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] read_word;

  assign sel = (bus.accel_id == ACCEL_ID);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake flags come from the state alone; enables only steer transitions.
  always_comb begin
    state_next    = state;
    can_write_int = 1'b0;
    can_read_int  = 1'b0;
    core_start    = 1'b0;
    case (state)
      DIV_IDLE: begin
        can_write_int = 1'b1;
        if (sel && bus.accel_write_enable) begin
          state_next = DIV_WAIT_DIV;
        end
      end
      DIV_WAIT_DIV: begin
        can_write_int = 1'b1;
        if (sel && bus.accel_write_enable) begin
          core_start = 1'b1;
          state_next = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (core_done) begin
          state_next = DIV_RES_Q;
        end
      end
      DIV_RES_Q: begin
        can_read_int = 1'b1;
        if (sel && bus.accel_read_enable) begin
          state_next = DIV_RES_R;
        end
      end
      DIV_RES_R: begin
        can_read_int = 1'b1;
        if (sel && bus.accel_read_enable) begin
          state_next = DIV_IDLE;
        end
      end
      default: begin
        state_next = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dividend <= '0;
    end else if (state == DIV_IDLE && sel && bus.accel_write_enable) begin
      dividend <= bus.accel_write_data;
    end
  end

`ifdef ACCEL_DIVIDER_SIGNED_EN
  logic divisor_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor_neg <= 1'b0;
    end else if (core_start) begin
      divisor_neg <= bus.accel_write_data[WIDTH-1];
    end
  end

  // The core only sees magnitudes; the most negative value maps onto itself as unsigned.
  always_comb begin
    core_dividend = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    core_divisor  = bus.accel_write_data[WIDTH-1] ?
                    (~bus.accel_write_data + 1'b1) : bus.accel_write_data;
    q_out = (dividend[WIDTH-1] ^ divisor_neg) ? (~core_q + 1'b1) : core_q;
    r_out = dividend[WIDTH-1] ? (~core_r + 1'b1) : core_r;
  end
`else
  always_comb begin
    core_dividend = dividend;
    core_divisor  = bus.accel_write_data;
    q_out         = core_q;
    r_out         = core_r;
  end
`endif

  accel_divider_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (core_start),
    .dividend (core_dividend),
    .divisor  (core_divisor),
    .quotient (core_q),
    .remainder(core_r),
    .done     (core_done)
  );

  always_comb begin
    read_word = '0;
    if (state == DIV_RES_Q) begin
      read_word = q_out;
    end else if (state == DIV_RES_R) begin
      read_word = r_out;
    end
  end

  // Every output is forced low when deselected so several accelerators can be OR-combined.
  assign bus.accel_can_write = sel & can_write_int;
  assign bus.accel_can_read  = sel & can_read_int;
  assign bus.accel_read_data = (sel && can_read_int) ? read_word : '0;

endmodule

// File: tb/tb_accel_divider.sv
// Directed testbench for accel_divider on the accel bus, instance id 1.
// The signed cases run only when ACCEL_DIVIDER_SIGNED_EN is defined.
module tb_accel_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  accel_divider_if #(.WIDTH(16)) bus ();

  accel_divider #(
    .ACCEL_ID(4'd1),
    .WIDTH   (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Writes the dividend and divisor, waits a bounded time for can_read, then drains both results.
  // The latency is the number of sampled cycles with can_read=0, counted from the divisor write cycle.
  task automatic do_divide(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic [15:0] r,
                           output int latency);
    @(negedge clk);
    bus.accel_id = 4'd1; bus.accel_write_enable = 1'b1; bus.accel_write_data = a;
    @(negedge clk);
    bus.accel_write_data = b;
    @(negedge clk);
    bus.accel_write_enable = 1'b0;
    #1;
    latency = 1;
    while (!bus.accel_can_read && latency < 40) begin
      @(negedge clk);
      #1;
      latency++;
    end
    if (!bus.accel_can_read) begin
      latency = -1;
      q = 'x;
      r = 'x;
      return;
    end
    q = bus.accel_read_data;
    bus.accel_read_enable = 1'b1;
    @(negedge clk);
    #1;
    r = bus.accel_read_data;
    @(negedge clk);
    bus.accel_read_enable = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.accel_id = 4'd1; bus.accel_write_enable = 1'b0; bus.accel_read_enable = 1'b0;
    bus.accel_write_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.accel_can_write !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_can_write: got %b expected 1", bus.accel_can_write);
    end
    checks++;
    if (bus.accel_can_read !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_can_read: got %b expected 0", bus.accel_can_read);
    end
    checks++;
    if (bus.accel_read_data !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_read_data: got %h expected 0000", bus.accel_read_data);
    end
  endtask

  task automatic test_unsigned;
    logic [15:0] vec_a [3] = '{16'd100, 16'hFFFF, 16'd5};
    logic [15:0] vec_b [3] = '{16'd7,   16'd1,    16'd0};
    logic [15:0] exp_q [3] = '{16'd14,  16'hFFFF, 16'hFFFF};
    logic [15:0] exp_r [3] = '{16'd2,   16'd0,    16'd5};
    logic [15:0] q, r;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_divide(vec_a[i], vec_b[i], q, r, lat);
      checks++;
      if (lat !== 17) begin
        errors++; $display("[TB] FAIL unsigned_latency[%0d]: got %0d expected 17", i, lat);
      end
      checks++;
      if (q !== exp_q[i]) begin
        errors++; $display("[TB] FAIL unsigned_quotient[%0d]: got %h expected %h", i, q, exp_q[i]);
      end
      checks++;
      if (r !== exp_r[i]) begin
        errors++; $display("[TB] FAIL unsigned_remainder[%0d]: got %h expected %h", i, r, exp_r[i]);
      end
      checks++;
      if (bus.accel_can_write !== 1'b1 || bus.accel_can_read !== 1'b0) begin
        errors++; $display("[TB] FAIL unsigned_idle_after[%0d]: got w=%b r=%b expected w=1 r=0",
                           i, bus.accel_can_write, bus.accel_can_read);
      end
    end
  endtask

  task automatic test_deselect;
    logic [15:0] q, r;
    int lat;
    @(negedge clk);
    bus.accel_id = 4'd2;
    #1;
    checks++;
    if ({bus.accel_can_write, bus.accel_can_read, bus.accel_read_data} !== 18'd0) begin
      errors++; $display("[TB] FAIL desel_idle_outputs: got w=%b r=%b d=%h expected all 0",
                         bus.accel_can_write, bus.accel_can_read, bus.accel_read_data);
    end
    bus.accel_write_enable = 1'b1; bus.accel_write_data = 16'd999;
    repeat (2) @(negedge clk);
    bus.accel_write_enable = 1'b0;
    do_divide(16'd20, 16'd6, q, r, lat);
    checks++;
    if (q !== 16'd3 || r !== 16'd2 || lat !== 17) begin
      errors++; $display("[TB] FAIL desel_writes_ignored: got q=%h r=%h lat=%0d expected q=0003 r=0002 lat=17",
                         q, r, lat);
    end

    @(negedge clk);
    bus.accel_id = 4'd1; bus.accel_write_enable = 1'b1; bus.accel_write_data = 16'd50;
    @(negedge clk);
    bus.accel_write_data = 16'd8;
    @(negedge clk);
    bus.accel_write_enable = 1'b0; bus.accel_id = 4'd2;
    #1;
    checks++;
    if ({bus.accel_can_write, bus.accel_can_read, bus.accel_read_data} !== 18'd0) begin
      errors++; $display("[TB] FAIL desel_busy_outputs: got w=%b r=%b d=%h expected all 0",
                         bus.accel_can_write, bus.accel_can_read, bus.accel_read_data);
    end
    repeat (25) @(negedge clk);
    #1;
    checks++;
    if ({bus.accel_can_write, bus.accel_can_read, bus.accel_read_data} !== 18'd0) begin
      errors++; $display("[TB] FAIL desel_result_outputs: got w=%b r=%b d=%h expected all 0",
                         bus.accel_can_write, bus.accel_can_read, bus.accel_read_data);
    end
    bus.accel_read_enable = 1'b1;
    @(negedge clk);
    bus.accel_read_enable = 1'b0; bus.accel_id = 4'd1;
    #1;
    checks++;
    if (bus.accel_can_read !== 1'b1 || bus.accel_read_data !== 16'd6) begin
      errors++; $display("[TB] FAIL desel_quotient_held: got r=%b d=%h expected r=1 d=0006",
                         bus.accel_can_read, bus.accel_read_data);
    end
    bus.accel_read_enable = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.accel_read_data !== 16'd2) begin
      errors++; $display("[TB] FAIL desel_remainder: got %h expected 0002", bus.accel_read_data);
    end
    @(negedge clk);
    bus.accel_read_enable = 1'b0;
    #1;
    checks++;
    if (bus.accel_can_write !== 1'b1 || bus.accel_can_read !== 1'b0) begin
      errors++; $display("[TB] FAIL desel_idle_after: got w=%b r=%b expected w=1 r=0",
                         bus.accel_can_write, bus.accel_can_read);
    end
  endtask

  task automatic test_reset_mid_busy;
    logic [15:0] q, r;
    int lat;
    @(negedge clk);
    bus.accel_id = 4'd1; bus.accel_write_enable = 1'b1; bus.accel_write_data = 16'd100;
    @(negedge clk);
    bus.accel_write_data = 16'd7;
    @(negedge clk);
    bus.accel_write_enable = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.accel_can_read !== 1'b0 || bus.accel_can_write !== 1'b1 || bus.accel_read_data !== 16'd0) begin
      errors++; $display("[TB] FAIL midreset_state: got w=%b r=%b d=%h expected w=1 r=0 d=0000",
                         bus.accel_can_write, bus.accel_can_read, bus.accel_read_data);
    end
    do_divide(16'd9, 16'd3, q, r, lat);
    checks++;
    if (lat !== 17) begin
      errors++; $display("[TB] FAIL midreset_latency: got %0d expected 17", lat);
    end
    checks++;
    if (q !== 16'd3 || r !== 16'd0) begin
      errors++; $display("[TB] FAIL midreset_result: got q=%h r=%h expected q=0003 r=0000", q, r);
    end
  endtask

`ifdef ACCEL_DIVIDER_SIGNED_EN
  task automatic test_signed;
    logic [15:0] vec_a [3] = '{16'hFFF9, 16'd7,    16'h8000};
    logic [15:0] vec_b [3] = '{16'd2,    16'hFFFE, 16'hFFFF};
    logic [15:0] exp_q [3] = '{16'hFFFD, 16'hFFFD, 16'h8000};
    logic [15:0] exp_r [3] = '{16'hFFFF, 16'h0001, 16'h0000};
    logic [15:0] q, r;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_divide(vec_a[i], vec_b[i], q, r, lat);
      checks++;
      if (q !== exp_q[i] || r !== exp_r[i] || lat !== 17) begin
        errors++; $display("[TB] FAIL signed[%0d]: got q=%h r=%h lat=%0d expected q=%h r=%h lat=17",
                           i, q, r, lat, exp_q[i], exp_r[i]);
      end
    end
  endtask
`endif

  initial begin
    bus.accel_id = 4'd1;
    bus.accel_write_enable = 1'b0;
    bus.accel_read_enable = 1'b0;
    bus.accel_write_data = '0;
    test_reset();
    test_unsigned();
    test_deselect();
    test_reset_mid_busy();
`ifdef ACCEL_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
